wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the main pipeline's MEM/WB write and two long-latency auxiliary units (aux0 = SAD unit, aux1 = multiply/divide unit).
- Pipeline writes always win and pass through with zero latency.
- Aux results are accepted through a valid/ready handshake, queued in a small FIFO, and drained into idle write-port slots.
- Exports pending-register hit flags so decode can stall on RAW and WAW hazards against queued aux results. Forces a pipeline bubble when the queue is starved.

Parameters:
- DEPTH, 4, aux write FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive blocked-drain cycles with FIFO full before Pipe_stall asserts.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Pipe_RegWrite  in  1  MEM/WB write enable.
- Pipe_WriteRegister  in  5  MEM/WB destination register.
- Pipe_WriteData  in  32  MEM/WB write data.
- Aux_valid  in  2  per-unit result valid.
- Aux_ready  out  2  per-unit accept.
- Aux_reg  in  2x5  per-unit destination register, packed {aux1, aux0}.
- Aux_data  in  2x32  per-unit result data, packed {aux1, aux0}.
- WB_RegWrite  out  1  register-file write enable.
- WB_WriteRegister  out  5  register-file write address.
- WB_WriteData  out  32  register-file write data.
- Chk_rs, Chk_rt, Chk_rd  in  5 each  decode-stage register numbers.
- Pend_hit  out  3  {rd, rt, rs} matches a queued FIFO entry.
- Pipe_stall  out  1  requests one bubble (pipe must present Pipe_RegWrite=0 the next cycle).
- Perf_aux_writes  out  32  aux writes committed (see Optional Feature).
- Perf_stall_cycles  out  32  cycles with Pipe_stall=1 (see Optional Feature).

Behaviour:
- Reset (async, Rst_n=0):
  - FIFO empty; rr pointer = aux0; starve counter = 0.
  - Pipe_stall=0, Aux_ready=0, perf counters=0.
  - Any in-flight or queued aux data is discarded.
- Write port (combinational):
  - pipe_active = Pipe_RegWrite & (Pipe_WriteRegister != 0).
  - If pipe_active: WB_* = pipe inputs.
  - Else if FIFO not empty: WB_* = FIFO head, pop on this edge.
  - Else: WB_RegWrite=0, WB_WriteRegister=0, WB_WriteData=0.
  - After reset, WB_RegWrite follows pipe inputs only.
- Accept:
  - At most one aux accepted per cycle.
  - Aux_ready[i] = Rst_n & ~full_next & (grant==i).
  - full_next accounts for a same-cycle pop, so push while full is allowed when popping.
  - Grant is round-robin between valid requesters: the pointer advances past the winner on each accept; a single requester always wins.
  - Transfer occurs when Aux_valid[i] & Aux_ready[i].
  - Accepted writes to $0 complete the handshake but are not enqueued.
- Ordering: the FIFO preserves accept order. Simultaneous push and pop on a non-empty FIFO keeps occupancy unchanged. Pointers wrap modulo DEPTH.
- Pend_hit[k] = 1 when any valid FIFO entry has a destination equal to the corresponding Chk input (nonzero only).
  - Entries being popped this cycle still count.
  - Decode must stall on any hit; this is the no-WAW guarantee: the pipe never writes a register that is pending in the FIFO.
- Starvation:
  - Counter increments each cycle the FIFO is full and pipe_active=1; otherwise it clears.
  - When the counter reaches STARVE_LIMIT, Pipe_stall is registered high for exactly one cycle and the counter clears.
  - The slot in which the pipe honours the bubble drains the head.
- Protocol errors:
  - Pipe_RegWrite during a requested bubble: the pipe still wins the port; the counter restarts.
  - An aux unit dropping valid without ready: legal, nothing is queued.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- Defined:
  - Perf_aux_writes increments on every FIFO pop.
  - Perf_stall_cycles increments each cycle Pipe_stall=1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both outputs tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package holds:
  - REG_W=5 and DATA_W=32.
  - NUM_AUX=2.
  - The packed write-request struct {reg[4:0], data[31:0]}.
  - Aux index constants AUX_SAD=0, AUX_MDU=1.
- One sub-module, wb_req_fifo: synchronous FIFO with push/pop, full/empty, and a per-entry valid+reg vector output for the Pend_hit comparison.

Test Plan:
- Reset mid-queue: enqueue 3 entries, pulse Rst_n low -> WB_RegWrite=0, Aux_ready=0, Pend_hit=0; no stale entry ever drains.
- Pipe priority:
  - Pipe writes $5=0x11 while aux0 enqueues $7=0x22 -> cycle N commits $5=0x11.
  - In the first cycle with no pipe write, $7=0x22 commits.
  - Pend_hit for Chk_rs=7 stays high until that cycle.
- Round-robin with both aux valid every cycle, pipe idle -> accept order aux0, aux1, aux0, aux1; commits in the same order.
- $0 handling:
  - aux1 writes $0 -> handshake completes, no FIFO occupancy, no WB write.
  - Pipe writes $0 with FIFO non-empty -> head drains that cycle.
- Full/starve with DEPTH=4, STARVE_LIMIT=8:
  - Fill the FIFO, hold pipe_active for 8 cycles -> Pipe_stall=1 for one cycle; Aux_ready stays 0 while full.
  - The bubble pops one entry and ready reasserts.
- WB_PERF_CNT_EN defined: after 6 aux commits and 2 stall pulses -> Perf_aux_writes=6, Perf_stall_cycles=2. Undefined -> both read 0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_AUX = 2;

  // Auxiliary unit indices within the packed Aux_* buses.
  localparam int unsigned AUX_SAD = 0;
  localparam int unsigned AUX_MDU = 1;

  // One queued register-file write.
  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Pipe bubble request: RUN normally, BUBBLE for the single cycle Pipe_stall is high.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } stall_state_t;

  // Register hazard match; $0 never creates a hazard.
  function automatic logic reg_match(input logic [REG_W-1:0] chk,
                                     input logic [REG_W-1:0] ent);
    return (chk != '0) && (chk == ent);
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Synchronous FIFO of pending aux write requests. Exposes per-slot valid and
// destination register so the parent can detect hazards against queued writes.
module wb_req_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  wb_req_t                     push_req,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output wb_req_t                     head,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [DEPTH-1:0][REG_W-1:0] entry_reg
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] offset;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: slot validity is derived from the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    offset      = '0;
    entry_valid = '0;
    entry_reg   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, offset} < count);
      entry_reg[i]   = mem[i].wreg;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline MEM/WB writes win with zero
// latency; SAD and MDU results are accepted round-robin, queued, and drained
// into idle write slots. Optional performance counters under WB_PERF_CNT_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Pipe_RegWrite,
  input  logic [REG_W-1:0]           Pipe_WriteRegister,
  input  logic [DATA_W-1:0]          Pipe_WriteData,
  input  logic [NUM_AUX-1:0]         Aux_valid,
  output logic [NUM_AUX-1:0]         Aux_ready,
  input  logic [NUM_AUX*REG_W-1:0]   Aux_reg,
  input  logic [NUM_AUX*DATA_W-1:0]  Aux_data,
  output logic                       WB_RegWrite,
  output logic [REG_W-1:0]           WB_WriteRegister,
  output logic [DATA_W-1:0]          WB_WriteData,
  input  logic [REG_W-1:0]           Chk_rs,
  input  logic [REG_W-1:0]           Chk_rt,
  input  logic [REG_W-1:0]           Chk_rd,
  output logic [2:0]                 Pend_hit,
  output logic                       Pipe_stall,
  output logic [31:0]                Perf_aux_writes,
  output logic [31:0]                Perf_stall_cycles
);

  localparam int unsigned AUX_IDX_W = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;
  localparam int unsigned CNT_W     = $clog2(STARVE_LIMIT + 1);

  logic                        pipe_active;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        pop;
  logic                        push;
  logic                        full_next;
  logic                        accept;
  wb_req_t                     fifo_head;
  wb_req_t                     push_req;
  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH-1:0][REG_W-1:0] entry_reg;
  logic [REG_W-1:0]            aux_reg_a  [NUM_AUX];
  logic [DATA_W-1:0]           aux_data_a [NUM_AUX];
  logic [AUX_IDX_W-1:0]        rr_ptr;
  logic [AUX_IDX_W-1:0]        grant;
  logic [AUX_IDX_W-1:0]        cand;
  logic                        grant_found;
  logic [2:0][REG_W-1:0]       chk_regs;
  logic [CNT_W-1:0]            starve_cnt;
  logic                        starving;
  logic                        starve_hit;
  stall_state_t                stall_state;
  stall_state_t                stall_next;

  assign pipe_active = Pipe_RegWrite & (Pipe_WriteRegister != '0);
  assign pop         = ~pipe_active & ~fifo_empty;
  // A same-cycle pop frees a slot, so a full queue may still accept.
  assign full_next   = fifo_full & ~pop;

  // Write-port mux: pipe first, then the queue head, otherwise idle.
  always_comb begin
    WB_RegWrite      = 1'b0;
    WB_WriteRegister = '0;
    WB_WriteData     = '0;
    if (pipe_active) begin
      WB_RegWrite      = 1'b1;
      WB_WriteRegister = Pipe_WriteRegister;
      WB_WriteData     = Pipe_WriteData;
    end else if (!fifo_empty) begin
      WB_RegWrite      = 1'b1;
      WB_WriteRegister = fifo_head.wreg;
      WB_WriteData     = fifo_head.data;
    end
  end

  // Unpack the per-unit request buses.
  always_comb begin
    for (int unsigned i = 0; i < NUM_AUX; i++) begin
      aux_reg_a[i]  = Aux_reg[i*REG_W +: REG_W];
      aux_data_a[i] = Aux_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin grant: first valid requester at or after the pointer.
  always_comb begin
    grant       = rr_ptr;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_AUX; k++) begin
      cand = AUX_IDX_W'((32'(rr_ptr) + k) % NUM_AUX);
      if (!grant_found && Aux_valid[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  // Only the granted unit sees ready, and only when the queue has room.
  always_comb begin
    Aux_ready = '0;
    for (int unsigned i = 0; i < NUM_AUX; i++) begin
      Aux_ready[i] = Rst_n & ~full_next & (grant == AUX_IDX_W'(i));
    end
  end

  assign accept        = |(Aux_valid & Aux_ready);
  assign push_req.wreg = aux_reg_a[grant];
  assign push_req.data = aux_data_a[grant];
  // Writes to $0 complete the handshake but are dropped.
  assign push          = accept & (push_req.wreg != '0);

  // Round-robin pointer moves past each accepted winner.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr_ptr <= AUX_IDX_W'(AUX_SAD);
    end else if (accept) begin
      rr_ptr <= (grant == AUX_IDX_W'(NUM_AUX - 1)) ? '0 : grant + 1'b1;
    end
  end

  wb_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .push        (push),
    .push_req    (push_req),
    .pop         (pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head),
    .entry_valid (entry_valid),
    .entry_reg   (entry_reg)
  );

  assign chk_regs = {Chk_rd, Chk_rt, Chk_rs};

  // Hazard flags against every live queue slot, including one popping now.
  always_comb begin
    Pend_hit = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (entry_valid[e] && reg_match(chk_regs[k], entry_reg[e])) begin
          Pend_hit[k] = 1'b1;
        end
      end
    end
  end

  assign starving   = fifo_full & pipe_active;
  assign starve_hit = starving & (starve_cnt == CNT_W'(STARVE_LIMIT - 1));

  // Count consecutive full-and-blocked cycles; clear on hit or any relief.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      starve_cnt <= '0;
    end else if (starving && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Bubble-request state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) stall_state <= ST_RUN;
    else        stall_state <= stall_next;
  end

  // Bubble request lasts exactly one cycle after the starve limit is reached.
  always_comb begin
    stall_next = ST_RUN;
    Pipe_stall = (stall_state == ST_BUBBLE);
    if (starve_hit) stall_next = ST_BUBBLE;
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] aux_writes_q;
  logic [31:0] stall_cycles_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      aux_writes_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (pop)        aux_writes_q   <= aux_writes_q + 1'b1;
      if (Pipe_stall) stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign Perf_aux_writes   = aux_writes_q;
  assign Perf_stall_cycles = stall_cycles_q;
`else
  assign Perf_aux_writes   = '0;
  assign Perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model checked
// every cycle, plus hand-computed literal expectations on directed vectors.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        Clk;
  logic        Rst_n;
  logic        Pipe_RegWrite;
  logic [4:0]  Pipe_WriteRegister;
  logic [31:0] Pipe_WriteData;
  logic [1:0]  Aux_valid;
  logic [1:0]  Aux_ready;
  logic [9:0]  Aux_reg;
  logic [63:0] Aux_data;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteRegister;
  logic [31:0] WB_WriteData;
  logic [4:0]  Chk_rs, Chk_rt, Chk_rd;
  logic [2:0]  Pend_hit;
  logic        Pipe_stall;
  logic [31:0] Perf_aux_writes;
  logic [31:0] Perf_stall_cycles;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Pipe_RegWrite(Pipe_RegWrite), .Pipe_WriteRegister(Pipe_WriteRegister),
    .Pipe_WriteData(Pipe_WriteData),
    .Aux_valid(Aux_valid), .Aux_ready(Aux_ready), .Aux_reg(Aux_reg), .Aux_data(Aux_data),
    .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData),
    .Chk_rs(Chk_rs), .Chk_rt(Chk_rt), .Chk_rd(Chk_rd), .Pend_hit(Pend_hit),
    .Pipe_stall(Pipe_stall),
    .Perf_aux_writes(Perf_aux_writes), .Perf_stall_cycles(Perf_stall_cycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_rr;
  int          m_cnt;
  logic        m_stall;
  logic [31:0] m_aw;
  logic [31:0] m_sc;

  always @(negedge Clk) begin : model
    logic        pa, pop, full, room, acc, g, hit;
    logic        e_we;
    logic [4:0]  e_reg, areg, c;
    logic [31:0] e_data, adata, e_paw, e_psc;
    logic [1:0]  e_ready;
    logic [2:0]  e_pend;
    pa = Pipe_RegWrite && (Pipe_WriteRegister != 5'd0);
    if (!Rst_n) begin
      mq.delete();
      m_rr = 1'b0; m_cnt = 0; m_stall = 1'b0; m_aw = '0; m_sc = '0;
      check("rst_wb_we",   {31'd0, WB_RegWrite}, {31'd0, pa});
      check("rst_ready",   {30'd0, Aux_ready}, 32'd0);
      check("rst_pend",    {29'd0, Pend_hit}, 32'd0);
      check("rst_stall",   {31'd0, Pipe_stall}, 32'd0);
      check("rst_perf_aw", Perf_aux_writes, 32'd0);
      check("rst_perf_sc", Perf_stall_cycles, 32'd0);
    end else begin
      pop  = !pa && (mq.size() > 0);
      full = (mq.size() == DEPTH);
      room = !full || pop;
      if (pa) begin
        e_we = 1'b1; e_reg = Pipe_WriteRegister; e_data = Pipe_WriteData;
      end else if (pop) begin
        e_we = 1'b1; e_reg = mq[0].r; e_data = mq[0].d;
      end else begin
        e_we = 1'b0; e_reg = '0; e_data = '0;
      end
      if (Aux_valid[m_rr])       g = m_rr;
      else if (Aux_valid[!m_rr]) g = !m_rr;
      else                       g = m_rr;
      e_ready = room ? (g ? 2'b10 : 2'b01) : 2'b00;
      acc     = room && Aux_valid[g];
      e_pend  = '0;
      for (int k = 0; k < 3; k++) begin
        c = (k == 0) ? Chk_rs : ((k == 1) ? Chk_rt : Chk_rd);
        hit = 1'b0;
        foreach (mq[j]) if (c != 5'd0 && mq[j].r == c) hit = 1'b1;
        e_pend[k] = hit;
      end
`ifdef WB_PERF_CNT_EN
      e_paw = m_aw; e_psc = m_sc;
`else
      e_paw = '0;   e_psc = '0;
`endif
      check("wb_we",   {31'd0, WB_RegWrite}, {31'd0, e_we});
      check("wb_reg",  {27'd0, WB_WriteRegister}, {27'd0, e_reg});
      check("wb_data", WB_WriteData, e_data);
      check("ready",   {30'd0, Aux_ready}, {30'd0, e_ready});
      check("pend",    {29'd0, Pend_hit}, {29'd0, e_pend});
      check("stall",   {31'd0, Pipe_stall}, {31'd0, m_stall});
      check("perf_aw", Perf_aux_writes, e_paw);
      check("perf_sc", Perf_stall_cycles, e_psc);
      // advance to the state after the coming clock edge
      if (m_stall) m_sc = m_sc + 1;
      if (pop) begin
        void'(mq.pop_front());
        m_aw = m_aw + 1;
      end
      if (acc) begin
        areg  = g ? Aux_reg[9:5]    : Aux_reg[4:0];
        adata = g ? Aux_data[63:32] : Aux_data[31:0];
        if (areg != 5'd0) mq.push_back('{r: areg, d: adata});
        m_rr = !g;
      end
      if (full && pa) begin
        m_cnt++;
        if (m_cnt == LIMIT) begin
          m_stall = 1'b1; m_cnt = 0;
        end else begin
          m_stall = 1'b0;
        end
      end else begin
        m_cnt = 0; m_stall = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic pwe, input logic [4:0] preg, input logic [31:0] pdat,
                       input logic [1:0] av, input logic [4:0] r0, input logic [31:0] d0,
                       input logic [4:0] r1, input logic [31:0] d1);
    Pipe_RegWrite      = pwe;
    Pipe_WriteRegister = preg;
    Pipe_WriteData     = pdat;
    Aux_valid          = av;
    Aux_reg            = {r1, r0};
    Aux_data           = {d1, d0};
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] exp_d;
    Rst_n = 1'b1;
    idle();
    Aux_valid = 2'b11;
    Chk_rs = '0; Chk_rt = '0; Chk_rd = '0;
    #1 Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    #1;
    check("lit_rst_ready", {30'd0, Aux_ready}, 32'd0);
    check("lit_rst_we",    {31'd0, WB_RegWrite}, 32'd0);
    check("lit_rst_stall", {31'd0, Pipe_stall}, 32'd0);
    Aux_valid = 2'b00;
    Rst_n = 1'b1;
    tick();

    // Pipe priority: pipe $5 wins while aux0 $7 is queued.
    drive(1'b1, 5'd5, 32'h11, 2'b01, 5'd7, 32'h22, 5'd0, 32'd0);
    Chk_rs = 5'd7;
    #1;
    check("lit_prio_reg",   {27'd0, WB_WriteRegister}, 32'd5);
    check("lit_prio_data",  WB_WriteData, 32'h11);
    check("lit_prio_ready", {30'd0, Aux_ready}, 32'b01);
    check("lit_prio_pend0", {29'd0, Pend_hit}, 32'd0);
    tick();
    drive(1'b1, 5'd9, 32'h33, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("lit_prio_reg2",  {27'd0, WB_WriteRegister}, 32'd9);
    check("lit_prio_pend1", {29'd0, Pend_hit}, 32'b001);
    tick();
    idle();
    #1;
    check("lit_drain_reg",  {27'd0, WB_WriteRegister}, 32'd7);
    check("lit_drain_data", WB_WriteData, 32'h22);
    check("lit_drain_pend", {29'd0, Pend_hit}, 32'b001);
    tick();
    #1;
    check("lit_after_we",   {31'd0, WB_RegWrite}, 32'd0);
    check("lit_after_pend", {29'd0, Pend_hit}, 32'd0);
    tick();

    // aux1 writes $0: handshake only.
    Chk_rs = '0;
    drive(1'b0, 5'd0, 32'd0, 2'b10, 5'd0, 32'd0, 5'd0, 32'h55);
    #1;
    check("lit_z_ready", {30'd0, Aux_ready}, 32'b10);
    check("lit_z_we",    {31'd0, WB_RegWrite}, 32'd0);
    tick();
    idle();
    #1;
    check("lit_z_we2", {31'd0, WB_RegWrite}, 32'd0);
    tick();

    // Round-robin with both units valid every cycle.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd1, 32'h100 + k, 5'd2, 32'h200 + k);
      #1;
      check("lit_rr_ready", {30'd0, Aux_ready}, (k % 2 == 0) ? 32'b01 : 32'b10);
      if (k > 0) begin
        exp_d = ((k - 1) % 2 == 0) ? 32'h100 + (k - 1) : 32'h200 + (k - 1);
        check("lit_rr_data", WB_WriteData, exp_d);
      end
      tick();
    end
    idle();
    #1;
    check("lit_rr_last_reg",  {27'd0, WB_WriteRegister}, 32'd2);
    check("lit_rr_last_data", WB_WriteData, 32'h203);
    tick();

    // Pipe write to $0 lets the queue head drain.
    drive(1'b0, 5'd0, 32'd0, 2'b01, 5'd3, 32'h33, 5'd0, 32'd0);
    #1;
    check("lit_p0_ready", {30'd0, Aux_ready}, 32'b01);
    tick();
    drive(1'b1, 5'd0, 32'hDEAD, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("lit_p0_reg",  {27'd0, WB_WriteRegister}, 32'd3);
    check("lit_p0_data", WB_WriteData, 32'h33);
    tick();
    idle();
    tick();

    // Reset mid-queue with three entries pending.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd20, 32'h2000 + i, 2'b01, 5'd21 + 5'(i), 32'hC0 + i, 5'd0, 32'd0);
      tick();
    end
    idle();
    Chk_rs = 5'd21;
    #1;
    check("lit_mq_pend_pre", {29'd0, Pend_hit}, 32'b001);
    check("lit_mq_we_pre",   {31'd0, WB_RegWrite}, 32'd1);
    Rst_n = 1'b0;
    #1;
    check("lit_mq_we",    {31'd0, WB_RegWrite}, 32'd0);
    check("lit_mq_ready", {30'd0, Aux_ready}, 32'd0);
    check("lit_mq_pend",  {29'd0, Pend_hit}, 32'd0);
    tick();
    tick();
    Rst_n = 1'b1;
    #1;
    check("lit_mq_we_post",   {31'd0, WB_RegWrite}, 32'd0);
    check("lit_mq_pend_post", {29'd0, Pend_hit}, 32'd0);
    tick();
    #1;
    check("lit_mq_we_post2", {31'd0, WB_RegWrite}, 32'd0);
    tick();

    // Fill and starve: two stall pulses, six aux commits in total.
    Chk_rs = 5'd11; Chk_rt = 5'd14; Chk_rd = 5'd5;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd10, 32'h1000 + i, 2'b01, 5'd11 + 5'(i), 32'hB0 + i, 5'd0, 32'd0);
      tick();
    end
    for (int i = 0; i < LIMIT; i++) begin
      drive(1'b1, 5'd10, 32'h1100 + i, 2'b01, 5'd15, 32'hB4, 5'd0, 32'd0);
      #1;
      check("lit_st_ready", {30'd0, Aux_ready}, 32'd0);
      check("lit_st_stall", {31'd0, Pipe_stall}, 32'd0);
      if (i == 0) check("lit_st_pend", {29'd0, Pend_hit}, 32'b011);
      tick();
    end
    drive(1'b1, 5'd10, 32'h1200, 2'b01, 5'd15, 32'hB4, 5'd0, 32'd0);
    #1;
    check("lit_st_pulse", {31'd0, Pipe_stall}, 32'd1);
    check("lit_st_ready2", {30'd0, Aux_ready}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 2'b01, 5'd15, 32'hB4, 5'd0, 32'd0);
    #1;
    check("lit_bub_stall", {31'd0, Pipe_stall}, 32'd0);
    check("lit_bub_reg",   {27'd0, WB_WriteRegister}, 32'd11);
    check("lit_bub_data",  WB_WriteData, 32'hB0);
    check("lit_bub_ready", {30'd0, Aux_ready}, 32'b01);
    tick();
    for (int i = 0; i < LIMIT; i++) begin
      drive(1'b1, 5'd10, 32'h1300 + i, 2'b01, 5'd16, 32'hB5, 5'd0, 32'd0);
      #1;
      check("lit_st2_stall", {31'd0, Pipe_stall}, 32'd0);
      tick();
    end
    #1;
    check("lit_st2_pulse", {31'd0, Pipe_stall}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 2'b01, 5'd16, 32'hB5, 5'd0, 32'd0);
    #1;
    check("lit_bub2_reg",   {27'd0, WB_WriteRegister}, 32'd12);
    check("lit_bub2_data",  WB_WriteData, 32'hB1);
    check("lit_bub2_ready", {30'd0, Aux_ready}, 32'b01);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("lit_fin_reg",  {27'd0, WB_WriteRegister}, 32'd13 + i);
      check("lit_fin_data", WB_WriteData, 32'hB2 + i);
      tick();
    end
    #1;
    check("lit_fin_we", {31'd0, WB_RegWrite}, 32'd0);
`ifdef WB_PERF_CNT_EN
    check("lit_perf_aw", Perf_aux_writes, 32'd6);
    check("lit_perf_sc", Perf_stall_cycles, 32'd2);
`else
    check("lit_perf_aw", Perf_aux_writes, 32'd0);
    check("lit_perf_sc", Perf_stall_cycles, 32'd0);
`endif
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
